reg_writeback_ctrl: RTL
=======================

// Module: reg_writeback_ctrl
// PURPOSE
//  Write-side driver for the 32x64 register file. Collects results from the ALU and load paths.
//  Arbitrates between them, buffering one colliding load. Drives rd/wrt_data/RegWrite into the register file.
//  Keeps a per-register busy scoreboard so decode stalls on RAW/WAW hazards.
// PARAMETERS
//  DATA_W      64  result / register width
//  REG_ADDR_W  6   register address width; only addresses 0..NUM_REGS-1 are legal
//  NUM_REGS    32  architectural registers; x0 is hard-wired zero
// PORTS
//  clk           in   1           single clock; all state updates on posedge
//  rst_n         in   1           synchronous, active-low reset
//  issue_valid   in   1           decode issues an instr that writes issue_rd
//  issue_rd      in   REG_ADDR_W  destination of issuing instr
//  issue_rs1     in   REG_ADDR_W  source 1 of issuing instr
//  issue_rs2     in   REG_ADDR_W  source 2 of issuing instr
//  issue_stall   out  1           comb: busy[rs1]|busy[rs2]|busy[rd] (x0 never busy)
//  alu_valid     in   1           ALU result present; always accepted, no backpressure
//  alu_rd        in   REG_ADDR_W  ALU destination
//  alu_data      in   DATA_W      ALU result
//  ld_valid      in   1           load result present
//  ld_ready      out  1           load accepted on posedge when ld_valid&ld_ready
//  ld_rd         in   REG_ADDR_W  load destination
//  ld_data       in   DATA_W      load data
//  rf_wrt_data   out  DATA_W      to register file write data (registered)
//  rf_rd         out  REG_ADDR_W  to register file rd (registered)
//  rf_reg_write  out  1           to register file RegWrite; high exactly 1 cycle per write
//  busy_mask     out  NUM_REGS    scoreboard; bit0 always 0
//  err_addr      out  1           1-cycle pulse: accepted result had rd >= NUM_REGS (dropped)
//  fwd_rs1_hit   out  1           forwarding hit on issue_rs1 (see CONFIGURATION)
//  fwd_rs1_data  out  DATA_W      forwarded value for rs1
//  fwd_rs2_hit   out  1           forwarding hit on issue_rs2
//  fwd_rs2_data  out  DATA_W      forwarded value for rs2
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): rf_* = 0, busy_mask = 0, err_addr = 0, skid empty, FSM = IDLE.
//   ld_ready = 0 while rst_n low. All fwd_* = 0.
//  Output stage: winner latched into rf_* at posedge N. rf_reg_write high during cycle N.
//   Register file commits at the negedge inside cycle N. If there is no winner, rf_reg_write = 0 and rf_rd/rf_wrt_data hold.
//  Priority: ALU > skid entry > direct load.
//  FSM IDLE (skid empty): ld_ready=1.
//   - alu_valid & ld_valid: ALU wins; load captured in skid -> HELD.
//   - Otherwise the sole valid source is written.
//  FSM HELD (skid full): ld_ready=0.
//   - alu_valid: ALU written; skid holds.
//   - !alu_valid: skid written -> IDLE.
//  rd==0 winner: consumed normally; rf_reg_write stays 0; scoreboard untouched.
//  rd>=NUM_REGS winner: consumed; rf_reg_write stays 0; err_addr pulses for 1 cycle.
//  Scoreboard: busy[issue_rd] set at posedge when issue_valid & !issue_stall & issue_rd in 1..NUM_REGS-1.
//   Bit clears at the posedge ending that rd's rf_reg_write cycle.
//   Simultaneous set & clear of the same bit: set wins.
//  ALU and skid targeting the same rd in flight is illegal (prevented by WAW stall); the bench asserts on it.
//  Mid-operation reset drops the skid entry and clears all busy bits; no write is issued that cycle.
// CONFIGURATION
//  WB_FORWARD_EN defined:
//   - fwd_rsX_hit = rf_reg_write & (rf_rd==issue_rsX) & (rf_rd!=0), combinationally.
//   - fwd_rsX_data = rf_wrt_data.
//   - issue_stall ignores busy[rsX] when fwd_rsX_hit.
//  WB_FORWARD_EN undefined: fwd_* tied to 0; stall purely from busy_mask.
// STRUCTURE
//  Package wb_pkg:
//   - DATA_W, REG_ADDR_W, NUM_REGS constants.
//   - wb_state_t enum {IDLE, HELD}.
//   - wb_result_t struct {rd, data}.
//  Sub-module wb_skid_buf: 1-entry wb_result_t holding register with full flag, load/unload strobes.
// TESTING
//  1 alu_valid, rd=5, data=0xDEAD -> next cycle rf_reg_write=1, rf_rd=5, rf_wrt_data=0xDEAD; busy[5] clears after.
//  2 alu (rd=3, 0x11) + ld (rd=4, 0x22) same cycle -> writes rd3 then rd4 on consecutive cycles.
//    ld_ready=0 for 1 cycle; FSM IDLE->HELD->IDLE.
//  3 HELD + alu_valid 3 cycles -> three ALU writes; skid written on the 4th cycle; ld_ready low throughout.
//  4 ALU result rd=0 -> rf_reg_write stays 0; rd=40 -> err_addr pulse, no write.
//  5 issue rd=7, then issue rs1=7 -> issue_stall=1 until writeback.
//    With WB_FORWARD_EN: stall drops in the write cycle, with fwd_rs1_hit=1 and fwd_rs1_data = written value.
//  6 rst_n low while HELD with busy[9] set -> next cycle skid empty, busy_mask=0, rf_reg_write=0, ld_ready=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
package wb_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 6;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_result_t;

    // Addresses at or above NUM_REGS do not exist in the register file.
    function automatic logic addr_legal(input logic [REG_ADDR_W-1:0] addr);
        return (addr < REG_ADDR_W'(NUM_REGS));
    endfunction

    // Scoreboard lookup; x0 and illegal addresses always read as not busy.
    function automatic logic busy_bit(input logic [NUM_REGS-1:0]   mask,
                                      input logic [REG_ADDR_W-1:0] addr);
        logic b;
        b = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (addr == REG_ADDR_W'(i)) b = mask[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Single-entry holding register for a load result that lost arbitration to the ALU.
module wb_skid_buf
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       unload,
    input  wb_result_t din,
    output logic       full,
    output wb_result_t dout
);

    // Capture on load, release on unload; load takes precedence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-side driver for the 32x64 register file: arbitrates ALU and load
// results (ALU > skid > direct load), drives the registered write port and
// keeps the per-register busy scoreboard used by decode to stall.
// Optional macro WB_FORWARD_EN: forward the write-port value to the issuing
// instruction's sources during the write cycle and drop the matching stall.
//
//  state | meaning
//  IDLE  | skid empty, loads accepted
//  HELD  | skid holds a load result, loads back-pressured
module reg_writeback_ctrl
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    output logic                  issue_stall,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0]     ld_data,
    output logic [DATA_W-1:0]     rf_wrt_data,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic                  rf_reg_write,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  err_addr,
    output logic                  fwd_rs1_hit,
    output logic [DATA_W-1:0]     fwd_rs1_data,
    output logic                  fwd_rs2_hit,
    output logic [DATA_W-1:0]     fwd_rs2_data
);

    wb_state_t           state_q, state_d;
    wb_result_t          win, ld_res, skid_q;
    logic                win_valid, win_wr;
    logic                skid_load, skid_unload, skid_full;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                set_en;

    assign ld_res.rd   = ld_rd;
    assign ld_res.data = ld_data;

    wb_skid_buf u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .unload (skid_unload),
        .din    (ld_res),
        .full   (skid_full),
        .dout   (skid_q)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Arbitration, skid control and load handshake; nothing is accepted during reset.
    always_comb begin
        state_d     = state_q;
        win_valid   = 1'b0;
        win         = '0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        ld_ready    = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    ld_ready = 1'b1;
                    if (alu_valid) begin
                        win_valid = 1'b1;
                        win.rd    = alu_rd;
                        win.data  = alu_data;
                        if (ld_valid) begin
                            skid_load = 1'b1;
                            state_d   = HELD;
                        end
                    end else if (ld_valid) begin
                        win_valid = 1'b1;
                        win       = ld_res;
                    end
                end
                HELD: begin
                    if (alu_valid) begin
                        win_valid = 1'b1;
                        win.rd    = alu_rd;
                        win.data  = alu_data;
                    end else begin
                        win_valid   = skid_full;
                        win         = skid_q;
                        skid_unload = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // x0 and out-of-range winners are consumed without touching the register file.
    assign win_wr = win_valid && (win.rd != '0) && addr_legal(win.rd);

    // Registered write port; address/data hold when there is nothing to write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_reg_write <= 1'b0;
            rf_rd        <= '0;
            rf_wrt_data  <= '0;
            err_addr     <= 1'b0;
        end else begin
            rf_reg_write <= win_wr;
            err_addr     <= win_valid && !addr_legal(win.rd);
            if (win_wr) begin
                rf_rd       <= win.rd;
                rf_wrt_data <= win.data;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_rs1_hit  = rf_reg_write && (rf_rd == issue_rs1) && (rf_rd != '0);
    assign fwd_rs2_hit  = rf_reg_write && (rf_rd == issue_rs2) && (rf_rd != '0);
    assign fwd_rs1_data = rf_wrt_data;
    assign fwd_rs2_data = rf_wrt_data;
`else
    assign fwd_rs1_hit  = 1'b0;
    assign fwd_rs2_hit  = 1'b0;
    assign fwd_rs1_data = '0;
    assign fwd_rs2_data = '0;
`endif

    // A forwarded source no longer needs to wait; the destination (WAW) always does.
    assign issue_stall = (busy_bit(busy_q, issue_rs1) && !fwd_rs1_hit) ||
                         (busy_bit(busy_q, issue_rs2) && !fwd_rs2_hit) ||
                          busy_bit(busy_q, issue_rd);

    assign set_en = issue_valid && !issue_stall && (issue_rd != '0) && addr_legal(issue_rd);

    // Scoreboard next value: clear on completed write, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rf_reg_write && (rf_rd == REG_ADDR_W'(i))) busy_d[i] = 1'b0;
            if (set_en && (issue_rd == REG_ADDR_W'(i)))    busy_d[i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_mask = busy_q;

endmodule
